// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eq_pkg
// Description : Shared constants and types for the 8-band equalizer datapath
//               and its serial output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package eq_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int NUM_BANDS = 8;
    localparam int GAIN_W    = 5;

    // Serializer FSM encoding
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/eq_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : eq_sample_fifo
// Description : Small synchronous sample FIFO with occupancy count. Pushes
//               while full and pops while empty are ignored. Read data is the
//               head entry, presented combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module eq_sample_fifo
    import eq_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/eq_sample_serializer.sv
`default_nettype none
// ============================================================================
// Module      : eq_sample_serializer
// Description : Buffers equalized samples and shifts them MSB-first to a DAC
//               with a generated bit clock (sclk) and a per-frame sync (fs).
//               Frames run back-to-back while samples are available; an empty
//               FIFO at a frame boundary produces a one-cycle underrun pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module eq_sample_serializer
    import eq_pkg::*;
#(
    parameter int DATA_W     = SAMPLE_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              sclk,
    output logic              sdata,
    output logic              fs,
    output logic              busy,
    output logic              underrun
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W = $clog2(DATA_W);

    logic [DIV_W-1:0]  r_div_cnt;
    logic [DIV_W-1:0]  w_div_next;
    logic              w_tick;
    logic              r_sclk;

    ser_state_t        r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_sdata;
    logic              r_fs;
    logic              r_busy;
    logic              r_underrun;

    logic [DATA_W-1:0] w_fifo_rdata;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;

    assign w_tick     = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_div_next = w_tick ? '0 : r_div_cnt + 1'b1;

    assign s_ready = (w_fifo_count < CNT_W'(FIFO_DEPTH));
    assign w_push  = s_valid && s_ready;
    // A sample leaves the FIFO only at a frame boundary: from IDLE, or on the
    // tick that ends the last bit of the current frame.
    assign w_pop   = w_tick && !w_fifo_empty &&
                     ((r_state == IDLE) || (r_bit_cnt == '0));

    eq_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (s_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    // Free-running bit timer; sclk is registered from the next count so it
    // falls on the same edge that updates sdata/fs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_sclk    <= (w_div_next >= DIV_W'(CLK_DIV / 2));
        end
    end

    // Frame FSM: load, shift and underrun handling, all advancing on tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_sdata    <= 1'b0;
            r_fs       <= 1'b0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_pop) begin
                r_shreg   <= w_fifo_rdata;
                r_sdata   <= w_fifo_rdata[DATA_W-1];
                r_fs      <= 1'b1;
                r_bit_cnt <= BIT_W'(DATA_W - 1);
                r_state   <= SHIFT;
                r_busy    <= 1'b1;
            end else if (w_tick) begin
                case (r_state)
                    SHIFT: begin
                        r_fs <= 1'b0;
                        if (r_bit_cnt != '0) begin
                            r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
                            r_sdata   <= r_shreg[DATA_W-2];
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                        end else begin
                            r_underrun <= 1'b1;
                            r_sdata    <= 1'b0;
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                        end
                    end
                    default: begin
                        r_sdata <= 1'b0;
                        r_fs    <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sclk     = r_sclk;
    assign sdata    = r_sdata;
    assign fs       = r_fs;
    assign busy     = r_busy;
    assign underrun = r_underrun;

endmodule
`default_nettype wire
